reg_byte_loader: RTL and testbench
==================================

Name: reg_byte_loader

Overview:
Initiator for the register E/FunSel/I write interface. Fetches one or two bytes from the 8-bit memory data path and issues the byte-level FunSel writes that assemble a 16-bit value in a target Register, e.g. IR or an address register. Sits between the memory read port and any 16-bit register. Keeps a shadow copy of the value the target holds after its writes.

Parameters:
TIMEOUT, 16, cycles allowed in a fetch state without MemValid before abort; 0 disables the timeout.
TO_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
Clock  input  1  single clock; every flop updates on its rising edge.
Reset  input  1  synchronous, active-high; sampled on the rising edge of Clock.
Start  input  1  command strobe; sampled only in IDLE.
Mode  input  2  sampled with Start: 00 LE16 (low byte then high), 01 BE16 (high byte then low), 10 ZX8 (one byte, zero-extend), 11 SX8 (one byte, sign-extend).
MemData  input  8  byte from memory; valid when MemValid=1.
MemValid  input  1  byte-available strobe; honoured only while MemReq=1.
MemReq  output  1  high in FETCH1 and FETCH2.
RegE  output  1  write enable to target register; registered.
RegFunSel  output  3  FunSel to target register; registered.
RegI  output  16  data to target register; always {8'h00, byte}; registered.
Shadow  output  16  value the target holds after the last RegE cycle.
Busy  output  1  state != IDLE.
Done  output  1  one-cycle pulse, coincident with the final RegE cycle.
Error  output  1  one-cycle pulse on timeout.

Behaviour:
- Reset (synchronous, priority over all inputs): state IDLE, counter 0. RegE, RegFunSel, RegI, Shadow, Done, Error, MemReq and Busy are all 0.
- States: IDLE, FETCH1, FETCH2, FINISH.
  - IDLE: Start=1 latches Mode and moves to FETCH1. Start outside IDLE is ignored. MemValid outside FETCH1/FETCH2 is ignored.
  - FETCH1: MemValid at an edge accepts the byte.
    - Two-byte modes go to FETCH2.
    - One-byte modes go to FINISH.
  - FETCH2: MemValid at an edge accepts the byte and moves to FINISH.
  - FINISH: lasts exactly one cycle, then goes to IDLE.
- Write issue: a byte accepted at edge k gives RegE=1 for exactly cycle k+1, with RegFunSel and RegI={8'h00,byte}.
  - The target register samples at edge k+1. Shadow updates at edge k+1.
  - Otherwise RegE=0. RegFunSel and RegI hold their last values.
- FunSel per byte:
  - LE16: byte1 101 (Shadow[7:0]), byte2 110 (Shadow[15:8]).
  - BE16: byte1 110, byte2 101.
  - ZX8: 100 (Shadow={8'h00,b}).
  - SX8: 111 (Shadow={{8{b[7]}},b}).
- Back-to-back bytes: the second byte may arrive in the cycle right after the first is accepted. RegE is then high for two consecutive cycles. Gaps of any length between bytes are legal; MemReq stays high.
- Done is high in the FINISH cycle. Busy falls at the edge ending FINISH. The earliest next Start is accepted at that same edge's following cycle, i.e. minimum 1 idle cycle.
- Timeout:
  - The counter clears on entry to FETCH1 and FETCH2, and increments each fetch cycle without MemValid.
  - When it reaches TIMEOUT: Error=1 for that cycle, state returns to IDLE at the next edge, and no further RegE is issued.
  - Partial writes already issued stand, and Shadow keeps them. Done is not pulsed.
  - MemValid in the same cycle as reaching TIMEOUT wins; the byte is accepted and there is no Error.
- Reset mid-operation: aborts immediately with no pending RegE and no Done. Shadow returns to 0. The target register is not reset by this block.

Test Plan:
- Reset, Start Mode=00, bytes 0x34 then 0x12 on consecutive cycles -> RegE two cycles with (101, 0x0034) then (110, 0x0012); Shadow=0x1234; Done pulses once with the second RegE; Busy low next cycle.
- Mode=11 byte 0x80 -> FunSel 111, RegI 0x0080, Shadow 0xFF80; then Mode=10 byte 0x80 -> FunSel 100, Shadow 0x0080.
- Mode=01, byte 0xAB, 3-cycle gap, byte 0xCD -> MemReq high throughout fetch, (110, 0x00AB) then (101, 0x00CD), Shadow 0xABCD.
- Mode=00, byte 0x55, withhold MemValid 16 cycles -> Error pulse on the 16th cycle, Busy drops, Shadow 0x0055, no Done; MemValid in the 16th cycle instead -> accepted, no Error.
- Start asserted while Busy, and MemValid=1 in IDLE -> no state change, no RegE.
- Reset asserted in FETCH2 after first byte -> next cycle all outputs 0, no RegE or Done follows.

Source files
------------

// File: rtl/reg_byte_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reg_byte_loader                                              |
// | Description : Fetches one or two bytes from the 8-bit memory read path and |
// |               issues byte-level FunSel writes that assemble a 16-bit value |
// |               in a target register (E/FunSel/I interface). Keeps a shadow  |
// |               copy of the value the target holds after its writes.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   Clock      in   1   rising-edge clock for every flop                     |
// |   Reset      in   1   synchronous active-high reset                        |
// |   Start      in   1   command strobe, sampled only while idle              |
// |   Mode       in   2   00 LE16, 01 BE16, 10 ZX8, 11 SX8 (latched on Start)  |
// |   MemData    in   8   memory byte, valid with MemValid                     |
// |   MemValid   in   1   byte strobe, honoured only while MemReq is high      |
// |   MemReq     out  1   fetch request, high while waiting for a byte         |
// |   RegE       out  1   registered write enable to the target register      |
// |   RegFunSel  out  3   registered FunSel to the target register            |
// |   RegI       out  16  registered write data, always {8'h00, byte}         |
// |   Shadow     out  16  value the target holds after the last write         |
// |   Busy       out  1   command in progress                                 |
// |   Done       out  1   pulse coincident with the final write cycle         |
// |   Error      out  1   pulse on fetch timeout                              |
// +----------------------------------------------------------------------------+

module reg_byte_loader #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Mode,
    input  logic [7:0]  MemData,
    input  logic        MemValid,
    output logic        MemReq,
    output logic        RegE,
    output logic [2:0]  RegFunSel,
    output logic [15:0] RegI,
    output logic [15:0] Shadow,
    output logic        Busy,
    output logic        Done,
    output logic        Error
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_FETCH1 = 2'd1;
    localparam logic [1:0] c_ST_FETCH2 = 2'd2;
    localparam logic [1:0] c_ST_FINISH = 2'd3;

    // Command modes; bit 1 set means a single-byte command.
    localparam logic [1:0] c_MODE_LE16 = 2'b00;
    localparam logic [1:0] c_MODE_BE16 = 2'b01;
    localparam logic [1:0] c_MODE_ZX8  = 2'b10;

    // FunSel codes understood by the target register.
    localparam logic [2:0] c_FS_ZX   = 3'b100;  // load {8'h00, I[7:0]}
    localparam logic [2:0] c_FS_LOW  = 3'b101;  // load low byte only
    localparam logic [2:0] c_FS_HIGH = 3'b110;  // load high byte only
    localparam logic [2:0] c_FS_SX   = 3'b111;  // load sign-extended byte

    localparam logic [TO_W-1:0] c_CNT_ONE = TO_W'(1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      r_mode;
    logic [TO_W-1:0] r_cnt;
    logic            r_rege;
    logic [2:0]      r_funsel;
    logic [7:0]      r_byte;
    logic [15:0]     r_shadow;

    // ------------------------------------------------------------------------
    // Combinational next-state / control
    // ------------------------------------------------------------------------
    logic [1:0]      w_state_nxt;
    logic [1:0]      w_mode_nxt;
    logic [TO_W-1:0] w_cnt_nxt;
    logic            w_accept;
    logic [2:0]      w_fs_nxt;
    logic            w_error;
    logic            w_to_hit;

    // w_to_hit is true in the fetch cycle that would be the TIMEOUT-th cycle
    // without a byte; MemValid in that same cycle still takes priority.
    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign w_to_hit = 1'b0;
        end else begin : g_timeout
            localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);
            assign w_to_hit = (r_cnt == c_TO_LAST);
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_fs_nxt    = r_funsel;
        w_error     = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (Start) begin
                    w_state_nxt = c_ST_FETCH1;
                    w_mode_nxt  = Mode;
                    w_cnt_nxt   = '0;
                end
            end

            c_ST_FETCH1: begin
                if (MemValid) begin
                    w_accept = 1'b1;
                    case (r_mode)
                        c_MODE_LE16: w_fs_nxt = c_FS_LOW;
                        c_MODE_BE16: w_fs_nxt = c_FS_HIGH;
                        c_MODE_ZX8:  w_fs_nxt = c_FS_ZX;
                        default:     w_fs_nxt = c_FS_SX;
                    endcase
                    if (r_mode[1]) begin
                        w_state_nxt = c_ST_FINISH;
                    end else begin
                        w_state_nxt = c_ST_FETCH2;
                        w_cnt_nxt   = '0;
                    end
                end else if (w_to_hit) begin
                    w_error     = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            c_ST_FETCH2: begin
                if (MemValid) begin
                    w_accept    = 1'b1;
                    // Second byte fills the half the first byte did not.
                    w_fs_nxt    = (r_mode == c_MODE_BE16) ? c_FS_LOW : c_FS_HIGH;
                    w_state_nxt = c_ST_FINISH;
                end else if (w_to_hit) begin
                    w_error     = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end

            c_ST_FINISH: begin
                w_state_nxt = c_ST_IDLE;
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential state, write issue and shadow tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= c_ST_IDLE;
            r_mode   <= 2'b00;
            r_cnt    <= '0;
            r_rege   <= 1'b0;
            r_funsel <= 3'b000;
            r_byte   <= 8'h00;
            r_shadow <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rege  <= w_accept;

            // FunSel and data hold their last values when no write is issued.
            if (w_accept) begin
                r_funsel <= w_fs_nxt;
                r_byte   <= MemData;
            end

            // The target samples at the edge that ends the RegE cycle; mirror
            // exactly what it will do with the presented FunSel and data.
            if (r_rege) begin
                case (r_funsel)
                    c_FS_ZX:   r_shadow       <= {8'h00, r_byte};
                    c_FS_LOW:  r_shadow[7:0]  <= r_byte;
                    c_FS_HIGH: r_shadow[15:8] <= r_byte;
                    c_FS_SX:   r_shadow       <= {{8{r_byte[7]}}, r_byte};
                    default:   ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign MemReq    = (r_state == c_ST_FETCH1) || (r_state == c_ST_FETCH2);
    assign Busy      = (r_state != c_ST_IDLE);
    // FINISH is only entered on a byte accept, so RegE is always high here.
    assign Done      = (r_state == c_ST_FINISH);
    assign Error     = w_error;
    assign RegE      = r_rege;
    assign RegFunSel = r_funsel;
    assign RegI      = {8'h00, r_byte};
    assign Shadow    = r_shadow;

endmodule

`default_nettype wire

// File: tb/tb_reg_byte_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_reg_byte_loader                                           |
// | Description : Self-checking bench for reg_byte_loader. A driver issues     |
// |               directed and random commands and pushes expected writes and  |
// |               errors into a queue; a monitor pops and compares them.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

module tb_reg_byte_loader;

    localparam int TO = 16;

    logic        clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  Mode;
    logic [7:0]  MemData;
    logic        MemValid;
    logic        MemReq;
    logic        RegE;
    logic [2:0]  RegFunSel;
    logic [15:0] RegI;
    logic [15:0] Shadow;
    logic        Busy;
    logic        Done;
    logic        Error;

    reg_byte_loader #(
        .TIMEOUT (TO),
        .TO_W    (8)
    ) u_dut (
        .Clock     (clk),
        .Reset     (Reset),
        .Start     (Start),
        .Mode      (Mode),
        .MemData   (MemData),
        .MemValid  (MemValid),
        .MemReq    (MemReq),
        .RegE      (RegE),
        .RegFunSel (RegFunSel),
        .RegI      (RegI),
        .Shadow    (Shadow),
        .Busy      (Busy),
        .Done      (Done),
        .Error     (Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [2:0]  fs;
        logic [15:0] regi;
        logic [15:0] sh;
        bit          last;
    } ev_t;

    ev_t         q[$];
    int          total;
    int          bad;
    bit          mon_en;
    logic [15:0] m_shadow;
    logic [2:0]  m_fs;
    logic [15:0] m_regi;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what the target register ends up holding follows from
    // which half of the 16-bit value each byte is meant to fill.
    task automatic model_write(input logic [1:0] mode, input int idx,
                               input logic [7:0] b, input bit last);
        ev_t e;
        logic [2:0] fs;
        case (mode)
            2'b00: begin
                if (idx == 0) begin
                    fs = 3'b101;
                    m_shadow = (m_shadow & 16'hFF00) | {8'h00, b};
                end else begin
                    fs = 3'b110;
                    m_shadow = (m_shadow & 16'h00FF) | ({8'h00, b} << 8);
                end
            end
            2'b01: begin
                if (idx == 0) begin
                    fs = 3'b110;
                    m_shadow = (m_shadow & 16'h00FF) | ({8'h00, b} << 8);
                end else begin
                    fs = 3'b101;
                    m_shadow = (m_shadow & 16'hFF00) | {8'h00, b};
                end
            end
            2'b10: begin
                fs = 3'b100;
                m_shadow = {8'h00, b};
            end
            default: begin
                fs = 3'b111;
                m_shadow = (b >= 8'h80) ? (16'hFF00 | {8'h00, b}) : {8'h00, b};
            end
        endcase
        e.err  = 1'b0;
        e.fs   = fs;
        e.regi = {8'h00, b};
        e.sh   = m_shadow;
        e.last = last;
        q.push_back(e);
        m_fs   = fs;
        m_regi = {8'h00, b};
    endtask

    task automatic model_error();
        ev_t e;
        e.err  = 1'b1;
        e.fs   = 3'b000;
        e.regi = 16'h0000;
        e.sh   = 16'h0000;
        e.last = 1'b0;
        q.push_back(e);
    endtask

    task automatic tick_fetch();
        @(negedge clk);
        chk("memreq_fetch", 32'(MemReq), 1);
        chk("busy_fetch", 32'(Busy), 1);
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            Start    = 1'b0;
            MemValid = 1'($urandom);
            MemData  = 8'($urandom);
            @(negedge clk);
            chk("busy_idle", 32'(Busy), 0);
            chk("memreq_idle", 32'(MemReq), 0);
            chk("funsel_hold", 32'(RegFunSel), 32'(m_fs));
            chk("regi_hold", 32'(RegI), 32'(m_regi));
            step();
        end
        MemValid = 1'b0;
    endtask

    task automatic chk_all_zero();
        chk("rst_rege", 32'(RegE), 0);
        chk("rst_funsel", 32'(RegFunSel), 0);
        chk("rst_regi", 32'(RegI), 0);
        chk("rst_shadow", 32'(Shadow), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_error", 32'(Error), 0);
        chk("rst_memreq", 32'(MemReq), 0);
        chk("rst_busy", 32'(Busy), 0);
    endtask

    // One command. Called in an idle cycle; returns in an idle cycle.
    // to_at selects the byte index whose fetch times out (-1 for none).
    task automatic do_txn(input logic [1:0] mode, input logic [7:0] b0, input logic [7:0] b1,
                          input int g0, input int g1, input int to_at);
        int nb;
        logic [7:0] bytes [2];
        int gaps [2];
        nb       = mode[1] ? 1 : 2;
        bytes[0] = b0;
        bytes[1] = b1;
        gaps[0]  = g0;
        gaps[1]  = g1;

        Start    = 1'b1;
        Mode     = mode;
        MemValid = 1'($urandom);
        MemData  = 8'($urandom);
        @(negedge clk);
        chk("busy_idle", 32'(Busy), 0);
        chk("memreq_idle", 32'(MemReq), 0);
        step();
        Start = 1'b0;
        Mode  = 2'($urandom);

        for (int i = 0; i < nb; i++) begin
            if (to_at == i) begin
                for (int c = 1; c <= TO; c++) begin
                    MemValid = 1'b0;
                    MemData  = 8'($urandom);
                    Start    = 1'($urandom);
                    if (c == TO) model_error();
                    tick_fetch();
                end
                Start    = 1'b0;
                MemValid = 1'b0;
                return;
            end
            for (int g = 0; g < gaps[i]; g++) begin
                MemValid = 1'b0;
                MemData  = 8'($urandom);
                Start    = 1'($urandom);
                tick_fetch();
            end
            MemValid = 1'b1;
            MemData  = bytes[i];
            Start    = 1'($urandom);
            model_write(mode, i, bytes[i], i == nb - 1);
            tick_fetch();
        end

        MemValid = 1'($urandom);
        MemData  = 8'($urandom);
        Start    = 1'($urandom);
        @(negedge clk);
        chk("busy_finish", 32'(Busy), 1);
        chk("memreq_finish", 32'(MemReq), 0);
        step();
        Start    = 1'b0;
        MemValid = 1'b0;
    endtask

    // Monitor: every write or error the DUT presents must match the queue head.
    initial begin
        ev_t e;
        bit pend;
        logic [15:0] pend_sh;
        pend = 1'b0;
        pend_sh = 16'h0000;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (pend) begin
                    chk("shadow", 32'(Shadow), 32'(pend_sh));
                    pend = 1'b0;
                end
                if (RegE === 1'b1) begin
                    if (q.size() == 0 || q[0].err) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got funsel=%0b regi=0x%0h expected no write",
                                 RegFunSel, RegI);
                    end else begin
                        e = q.pop_front();
                        chk("funsel", 32'(RegFunSel), 32'(e.fs));
                        chk("regi", 32'(RegI), 32'(e.regi));
                        chk("done_with_write", 32'(Done), 32'(e.last));
                        pend    = 1'b1;
                        pend_sh = e.sh;
                    end
                end else begin
                    chk("done_without_write", 32'(Done), 0);
                end
                if (Error === 1'b1) begin
                    total++;
                    if (q.size() != 0 && q[0].err) begin
                        e = q.pop_front();
                    end else begin
                        bad++;
                        $display("FAIL unexpected_error: got error=1 expected error=0");
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total    = 0;
        bad      = 0;
        mon_en   = 1'b0;
        m_shadow = 16'h0000;
        m_fs     = 3'b000;
        m_regi   = 16'h0000;
        Reset    = 1'b1;
        Start    = 1'b0;
        Mode     = 2'b00;
        MemData  = 8'h00;
        MemValid = 1'b0;
        step();
        step();
        @(negedge clk);
        chk_all_zero();
        Reset = 1'b0;
        step();
        mon_en = 1'b1;
        idle(2);

        // Directed cases
        do_txn(2'b00, 8'h34, 8'h12, 0, 0, -1);
        idle(1);
        do_txn(2'b11, 8'h80, 8'h00, 0, 0, -1);
        do_txn(2'b10, 8'h80, 8'h00, 0, 0, -1);
        do_txn(2'b01, 8'hAB, 8'hCD, 0, 3, -1);
        do_txn(2'b00, 8'h55, 8'h00, 0, 0, 1);      // timeout on second byte
        idle(1);
        do_txn(2'b00, 8'h55, 8'h66, 0, TO - 1, -1); // byte on the last allowed cycle
        do_txn(2'b01, 8'h11, 8'h22, TO - 1, 0, -1);
        do_txn(2'b11, 8'h7F, 8'h00, 0, 0, 0);       // timeout before any byte
        idle(3);

        // Reset while waiting for the second byte
        Start = 1'b1;
        Mode  = 2'b00;
        step();
        Start    = 1'b0;
        MemValid = 1'b1;
        MemData  = 8'h77;
        model_write(2'b00, 0, 8'h77, 1'b0);
        tick_fetch();
        MemValid = 1'b0;
        tick_fetch();
        Reset = 1'b1;
        @(negedge clk);
        step();
        Reset = 1'b0;
        @(negedge clk);
        chk_all_zero();
        m_shadow = 16'h0000;
        m_fs     = 3'b000;
        m_regi   = 16'h0000;
        step();
        idle(4);

        // Random commands
        for (int t = 0; t < 40; t++) begin
            logic [1:0] md;
            int g0;
            int g1;
            int to_at;
            md    = 2'($urandom);
            g0    = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            g1    = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 3));
            to_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, md[1] ? 0 : 1)) : -1;
            do_txn(md, 8'($urandom), 8'($urandom), g0, g1, to_at);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(3);
        chk("queue_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
